// File: rtl/adc_burst_sampler_if.sv
// rtl/adc_burst_sampler_if.sv - Burst readout stream between sampler and DMA/host path
interface adc_burst_sampler_if #(
    parameter int DATA_W = 12
) ();
    logic [2*DATA_W-1:0] m_data;
    logic                m_valid;
    logic                m_ready;
    logic                m_last;

    modport master (output m_data, output m_valid, output m_last, input m_ready);
    modport slave  (input m_data, input m_valid, input m_last, output m_ready);
endinterface

// File: rtl/adc_burst_sampler.sv
// rtl/adc_burst_sampler.sv - N-channel DDR ADC burst capture with pre-trigger ring and stream readout
module adc_burst_sampler #(
    parameter int N_CH   = 4,
    parameter int DATA_W = 12,
    parameter int DEPTH  = 256,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                     sys_clk,
    input  logic                     sys_rst,
    input  logic [N_CH*DATA_W-1:0]   q1_in,
    input  logic [N_CH*DATA_W-1:0]   q2_in,
    input  logic [CW-1:0]            ch_sel,
    input  logic                     arm,
    input  logic                     sw_trig,
    input  logic [DATA_W-1:0]        trig_level,
    input  logic [7:0]               decim,
    input  logic [AW-1:0]            pre_len,
    adc_burst_sampler_if.master      m_if,
    output logic                     busy,
    output logic                     triggered,
    output logic                     done
);
    typedef enum logic [2:0] {S_IDLE, S_PRE, S_WAIT, S_POST, S_READ} state_t;

    state_t              state;
    logic [CW-1:0]       ch_reg, sel_ch;
    logic [DATA_W-1:0]   level_reg, s2_q1, s2_q2, prev_q2;
    logic [7:0]          decim_reg, dec_cnt;
    logic [AW-1:0]       pre_reg, waddr, rd_start, start_now, rd_addr;
    logic [AW:0]         rd_cnt;
    logic [2*DATA_W-1:0] sel_pair, s1_pair, s2_pair, mem_q;
    logic [2*DATA_W-1:0] mem [DEPTH];
    logic capturing, wr, crossing, trig_evt, pend, take, out_free, issue, q_v, q_last;

    // Follow ch_sel live while idle so the pipeline already carries the right channel at arm.
    assign sel_ch = (state == S_IDLE) ? ch_sel : ch_reg;

    always_comb begin
        sel_pair = '0;
        for (int k = 0; k < N_CH; k++) begin
            if (sel_ch == CW'(k))
                sel_pair = {q2_in[k*DATA_W +: DATA_W], q1_in[k*DATA_W +: DATA_W]};
        end
    end

    always_ff @(posedge sys_clk) begin
        s1_pair <= sel_pair;
        s2_pair <= s1_pair;
        prev_q2 <= s2_q2;
    end

    assign s2_q1     = s2_pair[DATA_W-1:0];
    assign s2_q2     = s2_pair[2*DATA_W-1:DATA_W];
    assign capturing = (state == S_PRE) || (state == S_WAIT) || (state == S_POST);
    assign wr        = capturing && (dec_cnt == 8'd0);
    assign crossing  = ((prev_q2 < level_reg) && (s2_q1 >= level_reg)) ||
                       ((s2_q1 < level_reg) && (s2_q2 >= level_reg));
    assign trig_evt  = (state == S_WAIT) && (crossing || sw_trig);
    assign take      = wr && (pend || trig_evt);
    assign start_now = waddr - pre_reg;
    assign out_free  = !m_if.m_valid || m_if.m_ready;
    assign issue     = (state == S_READ) && (rd_cnt != (AW+1)'(DEPTH)) && (!q_v || out_free);
    assign rd_addr   = rd_start + rd_cnt[AW-1:0];
    assign busy      = (state != S_IDLE);
    assign done      = (state == S_READ) && m_if.m_valid && m_if.m_ready && m_if.m_last;

    always_ff @(posedge sys_clk) begin
        if (wr)
            mem[waddr] <= s2_pair;
        if (issue)
            mem_q <= mem[rd_addr];
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state        <= S_IDLE;
            ch_reg       <= '0;
            level_reg    <= '0;
            decim_reg    <= '0;
            pre_reg      <= '0;
            dec_cnt      <= '0;
            waddr        <= '0;
            rd_start     <= '0;
            rd_cnt       <= '0;
            pend         <= 1'b0;
            triggered    <= 1'b0;
            q_v          <= 1'b0;
            q_last       <= 1'b0;
            m_if.m_data  <= '0;
            m_if.m_valid <= 1'b0;
            m_if.m_last  <= 1'b0;
        end else begin
            if (wr) begin
                dec_cnt <= decim_reg;
                waddr   <= waddr + AW'(1);
            end else if (capturing) begin
                dec_cnt <= dec_cnt - 8'd1;
            end

            case (state)
                S_IDLE: begin
                    if (arm) begin
                        ch_reg    <= ch_sel;
                        level_reg <= trig_level;
                        decim_reg <= decim;
                        pre_reg   <= pre_len;
                        dec_cnt   <= decim;
                        waddr     <= '0;
                        triggered <= 1'b0;
                        pend      <= 1'b0;
                        state     <= (pre_len == '0) ? S_WAIT : S_PRE;
                    end
                end
                S_PRE: begin
                    if (wr && (waddr == pre_reg - AW'(1)))
                        state <= S_WAIT;
                end
                S_WAIT: begin
                    if (take) begin
                        triggered <= 1'b1;
                        pend      <= 1'b0;
                        rd_start  <= start_now;
                        rd_cnt    <= '0;
                        q_v       <= 1'b0;
                        // pre_len = DEPTH-1 leaves a single post-pair: the trigger write itself.
                        state     <= ((waddr + AW'(1)) == start_now) ? S_READ : S_POST;
                    end else if (trig_evt) begin
                        pend <= 1'b1;
                    end
                end
                S_POST: begin
                    if (wr && ((waddr + AW'(1)) == rd_start)) begin
                        rd_cnt <= '0;
                        q_v    <= 1'b0;
                        state  <= S_READ;
                    end
                end
                S_READ: begin
                    if (issue) begin
                        rd_cnt <= rd_cnt + (AW+1)'(1);
                        q_last <= (rd_cnt == (AW+1)'(DEPTH - 1));
                        q_v    <= 1'b1;
                    end else if (q_v && out_free) begin
                        q_v <= 1'b0;
                    end
                    // One-entry prefetch slot behind the output register keeps 1 word/cycle.
                    if (q_v && out_free) begin
                        m_if.m_data  <= mem_q;
                        m_if.m_valid <= 1'b1;
                        m_if.m_last  <= q_last;
                    end else if (m_if.m_valid && m_if.m_ready) begin
                        m_if.m_valid <= 1'b0;
                        m_if.m_last  <= 1'b0;
                    end
                    if (done)
                        state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_adc_burst_sampler.sv
// tb/tb_adc_burst_sampler.sv - Directed/randomized bench for adc_burst_sampler with burst reference model
module tb_adc_burst_sampler;
    localparam int N_CH = 4, DATA_W = 12, DEPTH = 256, AW = 8, MAXC = 30000;

    logic                   sys_clk = 1'b0;
    logic                   sys_rst;
    logic [N_CH*DATA_W-1:0] q1_in, q2_in;
    logic [1:0]             ch_sel;
    logic                   arm, sw_trig;
    logic [DATA_W-1:0]      trig_level;
    logic [7:0]             decim;
    logic [AW-1:0]          pre_len;
    logic                   busy, triggered, done;

    adc_burst_sampler_if #(.DATA_W(DATA_W)) sif ();

    adc_burst_sampler #(.N_CH(N_CH), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .q1_in(q1_in), .q2_in(q2_in),
        .ch_sel(ch_sel), .arm(arm), .sw_trig(sw_trig), .trig_level(trig_level),
        .decim(decim), .pre_len(pre_len), .m_if(sif), .busy(busy),
        .triggered(triggered), .done(done)
    );

    always #5 sys_clk = ~sys_clk;

    int          checks = 0, failures = 0, cyc = 0;
    logic [23:0] hist [MAXC];
    bit          swh [MAXC];
    int          dmode, ramp_n, arm_cyc, done_cnt;
    logic [11:0] lvl_val;
    bit          rnd_ready, stall_p, stall_l;
    logic [23:0] stall_d;
    logic [23:0] cap_d[$], exp_q[$];
    bit          cap_l[$], cap_dn[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // One clock: drive this cycle's inputs, log them, observe the stream, then advance.
    task automatic tick();
        logic [11:0] a, b;
        if (cyc >= MAXC) begin
            $display("FAIL cycle_budget observed=%0d expected<%0d", cyc, MAXC);
            $fatal(1, "cycle budget exhausted");
        end
        for (int k = 0; k < N_CH; k++) begin
            a = 12'($urandom_range(0, 4094));
            b = 12'($urandom_range(0, 4094));
            if (k == int'(ch_sel)) begin
                if (dmode == 0) begin
                    a = 12'(2 * ramp_n);
                    b = a + 12'd1;
                end else if (dmode == 2) begin
                    a = lvl_val;
                    b = lvl_val;
                end
                hist[cyc] = {b, a};
            end
            q1_in[k*DATA_W +: DATA_W] = a;
            q2_in[k*DATA_W +: DATA_W] = b;
        end
        swh[cyc] = sw_trig;
        sif.m_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        #1;
        if (stall_p) begin
            check("stall_valid", 32'(sif.m_valid), 32'd1);
            check("stall_data", 32'(sif.m_data), 32'(stall_d));
            check("stall_last", 32'(sif.m_last), 32'(stall_l));
        end
        if (sif.m_valid && sif.m_ready) begin
            cap_d.push_back(sif.m_data);
            cap_l.push_back(sif.m_last);
            cap_dn.push_back(done);
        end
        if (done) done_cnt++;
        stall_p = sif.m_valid && !sif.m_ready && !sys_rst;
        stall_d = sif.m_data;
        stall_l = sif.m_last;
        @(posedge sys_clk);
        #1;
        cyc++;
        ramp_n++;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_arm(input int ch, input int lvl, input int dec, input int pre);
        ch_sel = 2'(ch); trig_level = 12'(lvl); decim = 8'(dec); pre_len = 8'(pre);
        arm = 1'b1; arm_cyc = cyc;
        cap_d.delete(); cap_l.delete(); cap_dn.delete(); done_cnt = 0;
        tick();
        arm = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n = 0;
        while (done_cnt == 0 && n < budget) begin tick(); n++; end
        check({tag, "_done_seen"}, 32'(done_cnt != 0), 32'd1);
        ticks(2);
    endtask

    function automatic bit crossed(input int c, input int lvl);
        logic [11:0] q1, q2, pq2;
        if (c < 3) return 1'b0;
        q1 = hist[c-2][11:0]; q2 = hist[c-2][23:12]; pq2 = hist[c-3][23:12];
        return (int'(pq2) < lvl && int'(q1) >= lvl) || (int'(q1) < lvl && int'(q2) >= lvl);
    endfunction

    // Write k lands at cycle a+1+dec+k*(dec+1) holding the input of two cycles earlier.
    task automatic build_exp(input int a, input int dec, input int pre, input int lvl);
        int ws, fe, k;
        exp_q.delete();
        ws = (pre == 0) ? a + 1 : a + 1 + dec + (pre - 1) * (dec + 1) + 1;
        fe = -1;
        for (int c = ws; c < cyc; c++)
            if (fe < 0 && (swh[c] || crossed(c, lvl))) fe = c;
        if (fe < 0) return;
        k = pre;
        while (a + 1 + dec + k * (dec + 1) < fe) k++;
        for (int j = k - pre; j < k - pre + DEPTH; j++)
            exp_q.push_back(hist[a + 1 + dec + j * (dec + 1) - 2]);
    endtask

    task automatic verify(input string tag, input int dec, input int pre, input int lvl);
        build_exp(arm_cyc, dec, pre, lvl);
        check({tag, "_model_len"}, 32'(exp_q.size()), 32'(DEPTH));
        check({tag, "_words"}, 32'(cap_d.size()), 32'(DEPTH));
        check({tag, "_done_cnt"}, 32'(done_cnt), 32'd1);
        for (int i = 0; i < DEPTH && i < cap_d.size() && i < exp_q.size(); i++) begin
            check($sformatf("%s_word%0d", tag, i), 32'(cap_d[i]), 32'(exp_q[i]));
            check($sformatf("%s_last%0d", tag, i), 32'(cap_l[i]), 32'(i == DEPTH - 1));
            check($sformatf("%s_done%0d", tag, i), 32'(cap_dn[i]), 32'(i == DEPTH - 1));
        end
    endtask

    function automatic logic [11:0] cap_q1(input int i);
        logic [23:0] w;
        w = (i < cap_d.size()) ? cap_d[i] : 24'hFFFFFF;
        return w[11:0];
    endfunction

    initial begin
        int n, sw_cyc, j;
        logic [11:0] d;
        sys_rst = 1'b1; arm = 1'b0; sw_trig = 1'b0; ch_sel = 2'd2; trig_level = '0;
        decim = '0; pre_len = '0; dmode = 1; rnd_ready = 1'b0; ramp_n = 0; lvl_val = 12'd100;
        q1_in = '0; q2_in = '0; sif.m_ready = 1'b1; stall_p = 1'b0; done_cnt = 0;
        ticks(3);
        sys_rst = 1'b0;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_valid", 32'(sif.m_valid), 32'd0);
        check("rst_last", 32'(sif.m_last), 32'd0);
        check("rst_trig", 32'(triggered), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_data", 32'(sif.m_data), 32'd0);

        // Ramp on ch 2, level crossing at 999->1000, 64 pre-trigger pairs
        dmode = 0; ticks(2); ramp_n = 0;
        do_arm(2, 1000, 0, 64);
        wait_done("t1", 3000);
        verify("t1", 0, 64, 1000);
        check("t1_word64_q1", 32'(cap_q1(64)), 32'd1000);
        check("t1_triggered", 32'(triggered), 32'd1);

        // Software trigger with no pre-trigger history, random backpressure
        dmode = 1; rnd_ready = 1'b1; ch_sel = 2'd1; ticks(3);
        do_arm(1, 4095, 0, 0);
        ticks(9);
        sw_cyc = cyc; sw_trig = 1'b1; tick(); sw_trig = 1'b0;
        wait_done("t2", 2000);
        verify("t2", 0, 0, 4095);
        check("t2_word0", 32'(cap_d.size() > 0 ? cap_d[0] : 24'hFFFFFF), 32'(hist[sw_cyc-2]));
        ticks(5);
        check("t2_trig_sticky", 32'(triggered), 32'd1);

        // Decimation by 4 on a ramp
        dmode = 0; ch_sel = 2'd0; ticks(2); ramp_n = 0;
        do_arm(0, 3000, 3, 20);
        check("t3_trig_clr", 32'(triggered), 32'd0);
        wait_done("t3", 5000);
        verify("t3", 3, 20, 3000);
        for (int i = 1; i < DEPTH && i < cap_d.size(); i++) begin
            d = cap_q1(i) - cap_q1(i - 1);
            check($sformatf("t3_step%0d", i), 32'(d), 32'd8);
        end
        check("t3_trig_word", 32'(cap_q1(20) >= 12'd3000 && cap_q1(20) < 12'd3008), 32'd1);

        // Crossing and sw_trig in the same cycle; arm held during READ
        dmode = 2; lvl_val = 12'd100; rnd_ready = 1'b0; ch_sel = 2'd3; ticks(4);
        do_arm(3, 2000, 0, 8);
        ticks(20);
        lvl_val = 12'd3000; j = cyc; tick(); tick();
        check("t4_align", 32'(cyc), 32'(j + 2));
        sw_trig = 1'b1; tick(); sw_trig = 1'b0;
        n = 0;
        while (done_cnt == 0 && n < 2000) begin arm = sif.m_valid; tick(); n++; end
        arm = 1'b0;
        check("t4_done_seen", 32'(done_cnt != 0), 32'd1);
        ticks(4);
        check("t4_busy_after", 32'(busy), 32'd0);
        verify("t4", 0, 8, 2000);
        check("t4_trig_q1", 32'(cap_q1(8)), 32'd3000);
        check("t4_pre_q1", 32'(cap_q1(7)), 32'd100);

        // Crossing during PRE is discarded; a later crossing completes the burst
        lvl_val = 12'd100; ticks(4);
        do_arm(3, 2000, 0, 100);
        ticks(9);
        lvl_val = 12'd3000; tick(); lvl_val = 12'd100;
        ticks(150);
        lvl_val = 12'd3000;
        wait_done("t5", 2000);
        verify("t5", 0, 100, 2000);
        check("t5_trig_q1", 32'(cap_q1(100)), 32'd3000);
        check("t5_pre_q1", 32'(cap_q1(99)), 32'd100);

        // Reset during POST
        lvl_val = 12'd100; ticks(2);
        do_arm(3, 2000, 0, 16);
        ticks(30);
        sw_trig = 1'b1; tick(); sw_trig = 1'b0;
        n = 0;
        while (!triggered && n < 20) begin tick(); n++; end
        check("t6_post_trig", 32'(triggered), 32'd1);
        ticks(20);
        sys_rst = 1'b1; tick(); sys_rst = 1'b0;
        check("t6_post_busy", 32'(busy), 32'd0);
        check("t6_post_valid", 32'(sif.m_valid), 32'd0);
        check("t6_post_trig_clr", 32'(triggered), 32'd0);

        // Reset during READ
        do_arm(3, 2000, 0, 16);
        ticks(30);
        sw_trig = 1'b1; tick(); sw_trig = 1'b0;
        n = 0;
        while (cap_d.size() < 40 && n < 1000) begin tick(); n++; end
        check("t6_read_reached", 32'(cap_d.size() >= 40), 32'd1);
        sys_rst = 1'b1; tick(); sys_rst = 1'b0;
        check("t6_read_busy", 32'(busy), 32'd0);
        check("t6_read_valid", 32'(sif.m_valid), 32'd0);
        check("t6_read_last", 32'(sif.m_last), 32'd0);
        check("t6_read_trig_clr", 32'(triggered), 32'd0);

        // Fresh burst after the aborts
        dmode = 1; rnd_ready = 1'b1;
        do_arm(1, 4095, 1, 32);
        ticks(80);
        sw_trig = 1'b1; tick(); sw_trig = 1'b0;
        wait_done("t6", 3000);
        verify("t6", 1, 32, 4095);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
